detector_sentido_auto: RTL and testbench



---
 rtl/detector_sentido_auto.sv | 154 +++++++++++++++
 tb/tb_detector_sentido_auto.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/detector_sentido_auto.sv
// Gate direction detector: synchronises and debounces the two barrier sensors, then
// follows the A/B occlusion order to issue entry (s) / exit (r) pulses for the counter.
module detector_sentido_auto #(
  parameter int DEB_CICLOS = 4,
  parameter int CAPACIDAD  = 7,
  parameter int ANCHO      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sensor_a,
  input  logic             sensor_b,
  input  logic [ANCHO-1:0] cuenta,
  output logic             s,
  output logic             r,
  output logic             lleno,
  output logic             evento_invalido,
  output logic             error_seq
);

  localparam int              CW      = (DEB_CICLOS > 1) ? $clog2(DEB_CICLOS) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEB_CICLOS - 1);
  localparam logic [ANCHO-1:0] CAP    = ANCHO'(CAPACIDAD);

  typedef enum logic [2:0] {
    IDLE, ENT_A, ENT_AB, ENT_B, SAL_B, SAL_AB, SAL_A, ERR
  } estado_t;

  // Bit 1 carries sensor A and bit 0 sensor B, so filt_q reads directly as {a_f, b_f}.
  logic [1:0]         sync1_q, sync1_d;
  logic [1:0]         sync2_q, sync2_d;
  logic [1:0]         filt_q, filt_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  estado_t            estado_q, estado_d;
  logic               s_q, s_d;
  logic               r_q, r_d;
  logic               inv_q, inv_d;

  // NOTE: every always_comb output gets a default first; a path that skips an assignment would infer a latch.
  always_comb begin
    sync1_d = {sensor_a, sensor_b};
    sync2_d = sync1_q;
    filt_d  = filt_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        filt_d[i] = sync2_q[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_comb begin
    estado_d = estado_q;
    s_d      = 1'b0;
    r_d      = 1'b0;
    inv_d    = 1'b0;
    case (estado_q)
      IDLE:
        case (filt_q)
          2'b10:   estado_d = ENT_A;
          2'b01:   estado_d = SAL_B;
          2'b11:   estado_d = ERR;
          default: ;
        endcase
      ENT_A:
        case (filt_q)
          2'b11:   estado_d = ENT_AB;
          2'b00:   estado_d = IDLE;
          2'b01:   estado_d = ERR;
          default: ;
        endcase
      ENT_AB:
        case (filt_q)
          2'b01:   estado_d = ENT_B;
          2'b10:   estado_d = ENT_A;
          2'b00:   estado_d = ERR;
          default: ;
        endcase
      ENT_B:
        case (filt_q)
          2'b00: begin
            estado_d = IDLE;
            if (cuenta < CAP) s_d = 1'b1;
            else              inv_d = 1'b1;
          end
          2'b11:   estado_d = ENT_AB;
          2'b10:   estado_d = ERR;
          default: ;
        endcase
      SAL_B:
        case (filt_q)
          2'b11:   estado_d = SAL_AB;
          2'b00:   estado_d = IDLE;
          2'b10:   estado_d = ERR;
          default: ;
        endcase
      SAL_AB:
        case (filt_q)
          2'b10:   estado_d = SAL_A;
          2'b01:   estado_d = SAL_B;
          2'b00:   estado_d = ERR;
          default: ;
        endcase
      SAL_A:
        case (filt_q)
          2'b00: begin
            estado_d = IDLE;
            if (cuenta != '0) r_d = 1'b1;
            else              inv_d = 1'b1;
          end
          2'b11:   estado_d = SAL_AB;
          2'b01:   estado_d = ERR;
          default: ;
        endcase
      ERR:
        if (filt_q == 2'b00) estado_d = IDLE;
      default: estado_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      filt_q   <= '0;
      cnt_q    <= '0;
      estado_q <= IDLE;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      filt_q   <= filt_d;
      cnt_q    <= cnt_d;
      estado_q <= estado_d;
      s_q      <= s_d;
      r_q      <= r_d;
      inv_q    <= inv_d;
    end
  end

  assign s               = s_q;
  assign r               = r_q;
  assign evento_invalido = inv_q;
  assign error_seq       = (estado_q == ERR);
  assign lleno           = (cuenta == CAP);

endmodule

// File: tb/tb_detector_sentido_auto.sv
// Bench for detector_sentido_auto: directed gate scenarios plus random sensor traffic,
// every cycle compared against a sample-window / Gray-ring model of the gate.
module tb_detector_sentido_auto;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       sensor_a, sensor_b;
  logic [2:0] cuenta;
  logic       s, r, lleno, evento_invalido, error_seq;

  detector_sentido_auto #(.DEB_CICLOS(DEB), .CAPACIDAD(7), .ANCHO(3)) dut (
    .clk(clk), .rst(rst), .sensor_a(sensor_a), .sensor_b(sensor_b), .cuenta(cuenta),
    .s(s), .r(r), .lleno(lleno), .evento_invalido(evento_invalido), .error_seq(error_seq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int s_cnt, r_cnt, inv_cnt, err_cnt, s_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: raw samples reach the filter two edges late; a filtered level flips
  // once DEB consecutive seen samples disagree with it. Passes are walks on the Gray ring
  // 00-10-11-01-00; a two-bit jump is an error held until both sensors are clear.
  bit raw_a[$], raw_b[$], win_a[$], win_b[$];
  bit m_af, m_bf, m_err;
  bit [1:0] m_prev;
  int m_dir;  // 0 none, 1 entering, 2 leaving
  bit exp_s, exp_r, exp_inv, exp_err;

  always @(posedge clk) begin
    bit [1:0] p;
    bit sa, sb, all_a, all_b;
    cyc++;
    exp_s = 1'b0; exp_r = 1'b0; exp_inv = 1'b0;
    if (rst) begin
      raw_a.delete(); raw_b.delete(); win_a.delete(); win_b.delete();
      m_af = 1'b0; m_bf = 1'b0; m_err = 1'b0; m_prev = 2'b00; m_dir = 0;
    end else begin
      p = {m_af, m_bf};
      if (m_err) begin
        if (p == 2'b00) m_err = 1'b0;
      end else if (p != m_prev) begin
        if ((p ^ m_prev) == 2'b11) begin
          m_err = 1'b1;
          m_dir = 0;
        end else if (m_prev == 2'b00) begin
          m_dir = (p == 2'b10) ? 1 : 2;
        end else if (p == 2'b00) begin
          if (m_dir == 1 && m_prev == 2'b01) begin
            if (cuenta < 3'd7) exp_s = 1'b1; else exp_inv = 1'b1;
          end else if (m_dir == 2 && m_prev == 2'b10) begin
            if (cuenta != 3'd0) exp_r = 1'b1; else exp_inv = 1'b1;
          end
          m_dir = 0;
        end
      end
      m_prev = p;

      sa = (raw_a.size() >= 2) ? raw_a[raw_a.size()-2] : 1'b0;
      sb = (raw_b.size() >= 2) ? raw_b[raw_b.size()-2] : 1'b0;
      raw_a.push_back(sensor_a); raw_b.push_back(sensor_b);
      if (raw_a.size() > 2) void'(raw_a.pop_front());
      if (raw_b.size() > 2) void'(raw_b.pop_front());
      win_a.push_back(sa); win_b.push_back(sb);
      if (win_a.size() > DEB) void'(win_a.pop_front());
      if (win_b.size() > DEB) void'(win_b.pop_front());
      all_a = (win_a.size() == DEB);
      all_b = (win_b.size() == DEB);
      foreach (win_a[i]) if (win_a[i] == m_af) all_a = 1'b0;
      foreach (win_b[i]) if (win_b[i] == m_bf) all_b = 1'b0;
      if (all_a) begin m_af = ~m_af; win_a.delete(); end
      if (all_b) begin m_bf = ~m_bf; win_b.delete(); end
    end
    exp_err = m_err;
  end

  always @(posedge clk) begin
    #1;
    check("s",               32'(s),               32'(exp_s));
    check("r",               32'(r),               32'(exp_r));
    check("evento_invalido", 32'(evento_invalido), 32'(exp_inv));
    check("error_seq",       32'(error_seq),       32'(exp_err));
    check("lleno",           32'(lleno),           32'(cuenta == 3'd7));
    if (s) begin s_cnt++; s_cyc = cyc; end
    if (r) r_cnt++;
    if (evento_invalido) inv_cnt++;
    if (error_seq) err_cnt++;
  end

  task automatic drive(input bit a, input bit b, input int n);
    sensor_a = a;
    sensor_b = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    s_cnt = 0; r_cnt = 0; inv_cnt = 0; err_cnt = 0; s_cyc = 0;
  endtask

  task automatic pass(input bit entrada, input int hold_min, input int hold_max);
    if (entrada) begin
      drive(1, 0, $urandom_range(hold_min, hold_max));
      drive(1, 1, $urandom_range(hold_min, hold_max));
      drive(0, 1, $urandom_range(hold_min, hold_max));
    end else begin
      drive(0, 1, $urandom_range(hold_min, hold_max));
      drive(1, 1, $urandom_range(hold_min, hold_max));
      drive(1, 0, $urandom_range(hold_min, hold_max));
    end
    drive(0, 0, $urandom_range(hold_min, hold_max));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int clear_edge;
    rst = 1'b1; sensor_a = 1'b0; sensor_b = 1'b0; cuenta = 3'd3;
    clear_counts();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_s",   32'(s),               32'd0);
    check("rst_r",   32'(r),               32'd0);
    check("rst_inv", 32'(evento_invalido), 32'd0);
    check("rst_err", 32'(error_seq),       32'd0);

    // Normal entry with the edge-7 latency from the clearing of B.
    clear_counts();
    drive(1, 0, 10); drive(1, 1, 10); drive(0, 1, 10);
    clear_edge = cyc + 1;
    drive(0, 0, 10);
    check("entry_s_pulses", 32'(s_cnt), 32'd1);
    check("entry_r_pulses", 32'(r_cnt), 32'd0);
    check("entry_latency",  32'(s_cyc - clear_edge + 1), 32'(DEB + 3));

    cuenta = 3'd5;
    clear_counts();
    drive(0, 1, 10); drive(1, 1, 10); drive(1, 0, 10); drive(0, 0, 10);
    check("exit_r_pulses", 32'(r_cnt),   32'd1);
    check("exit_s_pulses", 32'(s_cnt),   32'd0);
    check("exit_err",      32'(err_cnt), 32'd0);

    // Bouncing A never settles long enough to be seen.
    clear_counts();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 2); drive(0, 0, 2);
    end
    drive(0, 0, 10);
    check("bounce_pulses", 32'(s_cnt + r_cnt + inv_cnt), 32'd0);
    check("bounce_err",    32'(err_cnt),                 32'd0);

    cuenta = 3'd7;
    check("lleno_full", 32'(lleno), 32'd1);
    clear_counts();
    drive(1, 0, 10); drive(1, 1, 10); drive(0, 1, 10); drive(0, 0, 10);
    check("full_s",   32'(s_cnt),   32'd0);
    check("full_inv", 32'(inv_cnt), 32'd1);
    cuenta = 3'd0;
    check("lleno_empty", 32'(lleno), 32'd0);
    clear_counts();
    drive(0, 1, 10); drive(1, 1, 10); drive(1, 0, 10); drive(0, 0, 10);
    check("empty_r",   32'(r_cnt),   32'd0);
    check("empty_inv", 32'(inv_cnt), 32'd1);

    cuenta = 3'd4;
    clear_counts();
    drive(1, 0, 10); drive(1, 1, 10); drive(1, 0, 10); drive(0, 0, 10);
    check("backout_pulses", 32'(s_cnt + r_cnt + inv_cnt), 32'd0);
    check("backout_err",    32'(err_cnt),                 32'd0);

    // A then B with no overlap: both filters flip together, a two-bit jump.
    clear_counts();
    drive(1, 0, 10); drive(0, 1, 10); drive(0, 0, 10);
    check("skip_err_cycles", 32'(err_cnt),              32'd10);
    check("skip_err_end",    32'(error_seq),            32'd0);
    check("skip_pulses",     32'(s_cnt + r_cnt + inv_cnt), 32'd0);

    // Reset while in ENT_B with B still blocked.
    drive(1, 0, 10); drive(1, 1, 10); drive(0, 1, 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_s",   32'(s),               32'd0);
    check("midrst_r",   32'(r),               32'd0);
    check("midrst_inv", 32'(evento_invalido), 32'd0);
    check("midrst_err", 32'(error_seq),       32'd0);
    clear_counts();
    drive(0, 1, 10);
    drive(0, 0, DEB + 3 + 4);
    check("midrst_no_s", 32'(s_cnt),   32'd0);
    check("midrst_no_r", 32'(r_cnt),   32'd0);
    check("midrst_inv2", 32'(inv_cnt), 32'd0);

    for (int i = 0; i < 200; i++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k < 4) begin
        pass(1'($urandom_range(0, 1)), 5, 9);
      end else if (k < 8) begin
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 8));
      end else if (k == 8) begin
        cuenta = 3'($urandom_range(0, 7));
      end else begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    drive(0, 0, 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
